pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle
// shared between the decode stage and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int SEL_W      = 4
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  branch_taken;
  logic                  freeze;
  logic                  flush;
  logic                  bubble;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src,
    output id_dest, id_wb_en, id_mem_r_en, branch_taken,
    input  freeze, flush, bubble, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src,
    input  id_dest, id_wb_en, id_mem_r_en, branch_taken,
    output freeze, flush, bubble, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order hazard controller: tracks post-ID destination
// tags and derives freeze/flush/bubble, forwarding, perf counters.
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 4,
  parameter int FWD_EN     = 0,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hif,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] retire_count
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [REG_ADDR_W-1:0] dest;
  } tag_t;

  tag_t             stage_q [DEPTH];
  logic [DEPTH-2:0] m1;
  logic [DEPTH-2:0] m2;
  logic             use1;
  logic             use2;
  logic             hz;
  logic             issue;
  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;

  // WB stage excluded: the register file writes on negedge
  always_comb begin
    use1 = hif.id_valid;
    use2 = hif.id_valid & hif.id_two_src;
    m1   = '0;
    m2   = '0;
    for (int s = 0; s < DEPTH-1; s++) begin
      m1[s] = use1 & stage_q[s].valid & stage_q[s].wb_en
            & (stage_q[s].dest == hif.id_src1);
      m2[s] = use2 & stage_q[s].valid & stage_q[s].wb_en
            & (stage_q[s].dest == hif.id_src2);
    end
  end

  always_comb begin
    hz   = 1'b0;
    sel1 = '0;
    sel2 = '0;
    if (FWD_EN != 0) begin
      hz = stage_q[0].mem_r_en & (m1[0] | m2[0]);
      // scan oldest to youngest so the youngest match wins
      for (int s = DEPTH-2; s >= 0; s--) begin
        if (m1[s]) sel1 = SEL_W'(s + 1);
        if (m2[s]) sel2 = SEL_W'(s + 1);
      end
    end else begin
      hz = |{m1, m2};
    end
  end

  assign issue        = hif.id_valid & ~hz & ~hif.branch_taken;
  assign hif.freeze   = hz & ~hif.branch_taken;
  assign hif.flush    = hif.branch_taken;
  assign hif.bubble   = ~issue;
  assign hif.fwd_sel1 = sel1;
  assign hif.fwd_sel2 = sel2;

  always_comb begin
    stage_valid = '0;
    for (int s = 0; s < DEPTH; s++)
      stage_valid[s] = stage_q[s].valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else begin
      if (issue) begin
        stage_q[0].valid    <= 1'b1;
        stage_q[0].wb_en    <= hif.id_wb_en;
        stage_q[0].mem_r_en <= hif.id_mem_r_en;
        stage_q[0].dest     <= hif.id_dest;
      end else begin
        stage_q[0] <= '0;
      end
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count  <= '0;
      retire_count <= '0;
    end else begin
      if (hif.freeze && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (stage_q[DEPTH-1].valid && retire_count != '1)
        retire_count <= retire_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a stall-mode/4-bit-counter instance
// and a forwarding-mode instance driven with identical ID traffic.
module tb_pipe_hazard_ctrl;

  localparam int D   = 3;
  localparam int AW  = 4;
  localparam int SW  = 4;
  localparam int CWA = 4;
  localparam int CWB = 32;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic [3:0] d;
    logic       wb;
    logic       ld;
    logic       br;
  } in_t;

  typedef struct packed {
    logic       afz;
    logic       abb;
    logic       bfz;
    logic       bbb;
    logic [3:0] f1;
    logic [3:0] f2;
    logic       fl;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } row_t;

  typedef struct packed {
    logic       v;
    logic       wb;
    logic       ld;
    logic [3:0] d;
  } mtag_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .SEL_W(SW)) ia ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .SEL_W(SW)) ib ();

  logic [D-1:0]   sva, svb;
  logic [CWA-1:0] sca, rca;
  logic [CWB-1:0] scb, rcb;

  pipe_hazard_ctrl #(
    .DEPTH(D), .REG_ADDR_W(AW), .FWD_EN(0), .CNT_W(CWA), .SEL_W(SW)
  ) ua (
    .clk(clk), .rst(rst), .hif(ia),
    .stage_valid(sva), .stall_count(sca), .retire_count(rca)
  );

  pipe_hazard_ctrl #(
    .DEPTH(D), .REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(CWB), .SEL_W(SW)
  ) ub (
    .clk(clk), .rst(rst), .hif(ib),
    .stage_valid(svb), .stall_count(scb), .retire_count(rcb)
  );

  // reference model: per-instance log of what entered EXE on each cycle
  mtag_t  lg [2][0:8191];
  int     n = 0;
  int     epoch = 0;
  longint est [2];
  longint ert [2];
  int     n_chk = 0;
  int     n_pass = 0;
  row_t   tab [17];

  function automatic longint cmax(int m);
    return (m == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic mtag_t stg(int m, int s);
    int c;
    c = n - 1 - s;
    if (c < epoch) return '0;
    return lg[m][c];
  endfunction

  function automatic bit mt(int m, int s, logic [3:0] r);
    mtag_t t;
    t = stg(m, s);
    return t.v && t.wb && (t.d == r);
  endfunction

  function automatic in_t mk_in(bit v, int s1, int s2, bit two,
                                int d, bit wb, bit ld, bit br);
    in_t r;
    r.v = v; r.s1 = 4'(s1); r.s2 = 4'(s2); r.two = two;
    r.d = 4'(d); r.wb = wb; r.ld = ld; r.br = br;
    return r;
  endfunction

  function automatic exp_t mk_ex(bit afz, bit abb, bit bfz, bit bbb,
                                 int f1, int f2, bit fl);
    exp_t r;
    r.afz = afz; r.abb = abb; r.bfz = bfz; r.bbb = bbb;
    r.f1 = 4'(f1); r.f2 = 4'(f2); r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
  endtask

  task automatic model(input int m, input in_t x,
                       output bit fz, output bit fl, output bit bb,
                       output bit iss, output int f1, output int f2);
    bit u1, u2, hz;
    mtag_t t0;
    hz = 0; f1 = 0; f2 = 0;
    u1 = x.v;
    u2 = x.v && x.two;
    if (m == 0) begin
      for (int s = 0; s < D-1; s++)
        if ((u1 && mt(m, s, x.s1)) || (u2 && mt(m, s, x.s2))) hz = 1;
    end else begin
      t0 = stg(m, 0);
      hz = t0.ld && ((u1 && mt(m, 0, x.s1)) || (u2 && mt(m, 0, x.s2)));
      for (int s = 0; s < D-1; s++) begin
        if (u1 && f1 == 0 && mt(m, s, x.s1)) f1 = s + 1;
        if (u2 && f2 == 0 && mt(m, s, x.s2)) f2 = s + 1;
      end
    end
    fz  = hz && !x.br;
    fl  = x.br;
    iss = x.v && !hz && !x.br;
    bb  = !iss;
  endtask

  task automatic drive(input in_t x);
    ia.id_valid = x.v;   ib.id_valid = x.v;
    ia.id_src1 = x.s1;   ib.id_src1 = x.s1;
    ia.id_src2 = x.s2;   ib.id_src2 = x.s2;
    ia.id_two_src = x.two; ib.id_two_src = x.two;
    ia.id_dest = x.d;    ib.id_dest = x.d;
    ia.id_wb_en = x.wb;  ib.id_wb_en = x.wb;
    ia.id_mem_r_en = x.ld; ib.id_mem_r_en = x.ld;
    ia.branch_taken = x.br; ib.branch_taken = x.br;
  endtask

  task automatic step(input in_t x, input bit te, input exp_t e);
    bit fz [2];
    bit fl [2];
    bit bb [2];
    bit is [2];
    int f1 [2];
    int f2 [2];
    mtag_t nt;
    logic [D-1:0] ev;
    if (n >= 8190) begin
      $display("FAIL cycle_budget: got %0d expected below 8190", n);
      $fatal(1, "cycle budget exhausted");
    end
    drive(x);
    #1;
    for (int m = 0; m < 2; m++)
      model(m, x, fz[m], fl[m], bb[m], is[m], f1[m], f2[m]);
    chk("A.freeze", ia.freeze, fz[0]);
    chk("A.flush", ia.flush, fl[0]);
    chk("A.bubble", ia.bubble, bb[0]);
    chk("A.fwd_sel1", ia.fwd_sel1, f1[0]);
    chk("A.fwd_sel2", ia.fwd_sel2, f2[0]);
    chk("B.freeze", ib.freeze, fz[1]);
    chk("B.flush", ib.flush, fl[1]);
    chk("B.bubble", ib.bubble, bb[1]);
    chk("B.fwd_sel1", ib.fwd_sel1, f1[1]);
    chk("B.fwd_sel2", ib.fwd_sel2, f2[1]);
    if (te) begin
      chk("tab.A.freeze", ia.freeze, e.afz);
      chk("tab.A.bubble", ia.bubble, e.abb);
      chk("tab.B.freeze", ib.freeze, e.bfz);
      chk("tab.B.bubble", ib.bubble, e.bbb);
      chk("tab.B.fwd_sel1", ib.fwd_sel1, e.f1);
      chk("tab.B.fwd_sel2", ib.fwd_sel2, e.f2);
      chk("tab.flush", ia.flush, e.fl);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (fz[m] && est[m] < cmax(m)) est[m]++;
      if (stg(m, D-1).v && ert[m] < cmax(m)) ert[m]++;
      nt = '0;
      if (is[m]) begin
        nt.v = 1'b1; nt.wb = x.wb; nt.ld = x.ld; nt.d = x.d;
      end
      lg[m][n] = nt;
    end
    n++;
    @(negedge clk);
    for (int s = 0; s < D; s++) ev[s] = stg(0, s).v;
    chk("A.stage_valid", sva, ev);
    for (int s = 0; s < D; s++) ev[s] = stg(1, s).v;
    chk("B.stage_valid", svb, ev);
    chk("A.stall_count", sca, est[0]);
    chk("A.retire_count", rca, ert[0]);
    chk("B.stall_count", scb, est[1]);
    chk("B.retire_count", rcb, ert[1]);
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b0;
    #1;
    chk("rst.A.stage_valid", sva, 0);
    chk("rst.B.stage_valid", svb, 0);
    chk("rst.A.stall_count", sca, 0);
    chk("rst.A.retire_count", rca, 0);
    chk("rst.B.stall_count", scb, 0);
    chk("rst.B.retire_count", rcb, 0);
    epoch = n;
    est[0] = 0; est[1] = 0;
    ert[0] = 0; ert[1] = 0;
    #1 rst = 1'b1;
  endtask

  in_t  idle;
  in_t  x;
  exp_t nx;

  initial begin
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
    nx   = mk_ex(0, 0, 0, 0, 0, 0, 0);
    est[0] = 0; est[1] = 0; ert[0] = 0; ert[1] = 0;

    tab[0]  = '{mk_in(1,0,0,0,3,1,0,0), mk_ex(0,0,0,0,0,0,0)};
    tab[1]  = '{mk_in(1,3,0,0,9,0,0,0), mk_ex(1,1,0,0,1,0,0)};
    tab[2]  = '{mk_in(1,3,0,0,9,0,0,0), mk_ex(1,1,0,0,2,0,0)};
    tab[3]  = '{mk_in(1,3,0,0,9,0,0,0), mk_ex(0,0,0,0,0,0,0)};
    tab[4]  = '{idle,                   mk_ex(0,1,0,1,0,0,0)};
    tab[5]  = '{idle,                   mk_ex(0,1,0,1,0,0,0)};
    tab[6]  = '{mk_in(1,0,0,0,5,1,1,0), mk_ex(0,0,0,0,0,0,0)};
    tab[7]  = '{mk_in(1,0,5,1,0,0,0,0), mk_ex(1,1,1,1,0,1,0)};
    tab[8]  = '{mk_in(1,0,5,1,0,0,0,0), mk_ex(1,1,0,0,0,2,0)};
    tab[9]  = '{mk_in(1,0,5,1,0,0,0,0), mk_ex(0,0,0,0,0,0,0)};
    tab[10] = '{idle,                   mk_ex(0,1,0,1,0,0,0)};
    tab[11] = '{idle,                   mk_ex(0,1,0,1,0,0,0)};
    tab[12] = '{mk_in(1,0,0,0,5,1,1,0), mk_ex(0,0,0,0,0,0,0)};
    tab[13] = '{mk_in(1,0,5,0,0,0,0,0), mk_ex(0,0,0,0,0,0,0)};
    tab[14] = '{mk_in(1,0,0,0,6,1,1,0), mk_ex(0,0,0,0,0,0,0)};
    tab[15] = '{mk_in(1,6,0,0,0,0,0,1), mk_ex(0,1,0,1,1,0,1)};
    tab[16] = '{idle,                   mk_ex(0,1,0,1,0,0,0)};

    // reset-state combinational outputs
    #1 drive(mk_in(1, 0, 0, 0, 0, 0, 0, 1));
    #1;
    chk("rst.A.flush", ia.flush, 1);
    chk("rst.A.bubble", ia.bubble, 1);
    chk("rst.A.freeze", ia.freeze, 0);
    chk("rst.B.fwd_sel1", ib.fwd_sel1, 0);
    chk("rst.A.stage_valid", sva, 0);
    chk("rst.B.retire_count", rcb, 0);
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst.A.flush_lo", ia.flush, 0);
    chk("rst.A.bubble_lo", ia.bubble, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) step(tab[i].i, 1'b1, tab[i].e);
    chk("tab.A.stall_total", sca, 4);
    chk("tab.B.stall_total", scb, 1);

    // back-to-back retirement latency, then reset mid-stream
    rst_pulse();
    for (int k = 0; k < 4; k++) step(mk_in(1, 0, 0, 0, k+1, 1, 0, 0), 1'b0, nx);
    step(idle, 1'b0, nx);
    step(idle, 1'b0, nx);
    chk("lat.A.retire_edge6", rca, 3);
    step(idle, 1'b0, nx);
    chk("lat.A.retire_edge7", rca, 4);
    chk("lat.B.retire_edge7", rcb, 4);
    step(mk_in(1, 0, 0, 0, 2, 1, 0, 0), 1'b0, nx);
    step(mk_in(1, 0, 0, 0, 3, 1, 0, 0), 1'b0, nx);
    rst_pulse();
    step(idle, 1'b0, nx);

    // stall counter saturation on the 4-bit instance
    for (int k = 0; k < 36; k++) step(mk_in(1, 7, 0, 0, 7, 1, 0, 0), 1'b0, nx);
    chk("sat.A.stall_count", sca, 15);
    chk("sat.B.stall_count", scb, 0);

    rst_pulse();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) rst_pulse();
      x = mk_in($urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
      step(x, 1'b0, nx);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
